// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package rr_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int REQ_IDX_W = $clog2(N_REQ_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_bus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above
// start_i (wrapping), with the excl_i bits masked out.
import rr_arb_pkg::*;

module rr_pick #(
    parameter int N = N_REQ_DEF,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    input  logic [N-1:0] excl_i,
    output logic [N-1:0] win_oh_o,
    output logic [W-1:0] win_idx_o,
    output logic         win_vld_o
);

    logic [N-1:0] cand;
    logic [W-1:0] j;

    assign cand = req_i & ~excl_i;

    // N is a power of two, so the W-bit add wraps modulo N for free
    always_comb begin
        win_vld_o = 1'b0;
        win_idx_o = '0;
        j         = '0;
        for (int i = 0; i < N; i++) begin
            j = start_i + W'(i);
            if (!win_vld_o && cand[j]) begin
                win_vld_o = 1'b1;
                win_idx_o = j;
            end
        end
    end

    assign win_oh_o = win_vld_o ? (N'(1) << win_idx_o) : '0;

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter with grant hold; the owner keeps the grant until done or withdrawal.
// Define RR_ARB_TIMEOUT_EN to build the hold counter that forces release after TIMEOUT cycles.
import rr_arb_pkg::*;

module rr_bus_arbiter #(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    input  logic                     en,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;

    logic             own_rel, tmo_hit, rel, arb_ok, new_grant;
    logic [IW-1:0]    pick_ptr;
    logic [N_REQ-1:0] excl;
    logic [N_REQ-1:0] win_oh;
    logic [IW-1:0]    win_idx;
    logic             win_vld;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;
    assign tmo_hit = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign own_rel  = (state_q == BUSY) && (done[owner_q] || !req[owner_q]);
    assign rel      = own_rel || tmo_hit;
    // On release the search restarts after the owner and skips it for this cycle
    assign pick_ptr = rel ? owner_q + IW'(1) : ptr_q;
    assign excl     = rel ? (N_REQ'(1) << owner_q) : '0;
    assign arb_ok   = en && win_vld;

    rr_pick #(.N(N_REQ), .W(IW)) u_pick (
        .req_i     (req),
        .start_i   (pick_ptr),
        .excl_i    (excl),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_ok) state_d = BUSY;
            BUSY:    if (rel && !arb_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        new_grant = 1'b0;
        if (state_q == IDLE || rel) begin
            if (rel) ptr_d = pick_ptr;
            if (arb_ok) begin
                gnt_d     = win_oh;
                owner_d   = win_idx;
                new_grant = 1'b1;
            end else begin
                gnt_d = '0;
            end
        end
`ifdef RR_ARB_TIMEOUT_EN
        terr_d = tmo_hit && !own_rel;
        cnt_d  = cnt_q;
        if (new_grant)             cnt_d = '0;
        else if (state_q == BUSY)  cnt_d = cnt_q + CW'(1);
`endif
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q == BUSY);
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: expected outputs are queued with each
// stimulus step and popped for comparison one cycle later.
module tb_rr_bus_arbiter;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic       en = 1'b0;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       terr;
    } exp_t;

    exp_t sb[$];

    rr_bus_arbiter #(.N_REQ(4), .TIMEOUT(4)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .en          (en),
        .gnt         (gnt),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        x = sb.pop_front();
        tests++;
        assert (gnt === x.gnt) else begin
            fails++; $error("FAIL %s gnt got %b exp %b", tag, gnt, x.gnt);
        end
        tests++;
        assert (owner === x.owner) else begin
            fails++; $error("FAIL %s owner got %0d exp %0d", tag, owner, x.owner);
        end
        tests++;
        assert (busy === x.busy) else begin
            fails++; $error("FAIL %s busy got %b exp %b", tag, busy, x.busy);
        end
        tests++;
        assert (timeout_err === x.terr) else begin
            fails++; $error("FAIL %s timeout_err got %b exp %b", tag, timeout_err, x.terr);
        end
    endtask

    // Drive one cycle of inputs, queue what must be visible after the next edge
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                       input logic e, input logic [3:0] eg, input logic [1:0] eo,
                       input logic eb, input logic et, input string tag);
        exp_t x;
        rst = r; req = rq; done = dn; en = e;
        x.gnt = eg; x.owner = eo; x.busy = eb; x.terr = et;
        sb.push_back(x);
        @(posedge CLK);
        #1;
        check(tag);
    endtask

    initial begin
        // reset with all requesting
        cyc(1, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "rst0");
        cyc(1, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "rst1");
        cyc(0, 4'b1111, 4'b0000, 1, 4'b0001, 2'd0, 1, 0, "first_gnt");

        // full load rotation, done in first granted cycle, no dead cycles
        cyc(0, 4'b1111, 4'b0001, 1, 4'b0010, 2'd1, 1, 0, "load1");
        cyc(0, 4'b1111, 4'b0010, 1, 4'b0100, 2'd2, 1, 0, "load2");
        cyc(0, 4'b1111, 4'b0100, 1, 4'b1000, 2'd3, 1, 0, "load3");
        cyc(0, 4'b1111, 4'b1000, 1, 4'b0001, 2'd0, 1, 0, "load_wrap");

        // owner 0 withdraws, then skip 2 when 1 finishes
        cyc(0, 4'b1010, 4'b0000, 1, 4'b0010, 2'd1, 1, 0, "skip_own1");
        cyc(0, 4'b1010, 4'b0010, 1, 4'b1000, 2'd3, 1, 0, "skip_to3");
        cyc(0, 4'b0000, 4'b1000, 1, 4'b0000, 2'd3, 0, 0, "idle_keep_own");
        // ptr wrapped to 0 after owner 3, so 0 beats 1
        cyc(0, 4'b0011, 4'b0000, 1, 4'b0001, 2'd0, 1, 0, "ptr_wrap0");
        cyc(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "release0");

        // enable gating
        cyc(0, 4'b0100, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "en_off0");
        cyc(0, 4'b0100, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "en_off1");
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "en_rise");
        cyc(0, 4'b0100, 4'b0000, 0, 4'b0100, 2'd2, 1, 0, "en_drop_hold0");
        cyc(0, 4'b0100, 4'b0000, 0, 4'b0100, 2'd2, 1, 0, "en_drop_hold1");
        cyc(0, 4'b0100, 4'b0100, 0, 4'b0000, 2'd2, 0, 0, "en_off_done");

        // withdrawal with another requester pending; non-owner done ignored
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "wd_grant");
        cyc(0, 4'b0001, 4'b0000, 1, 4'b0001, 2'd0, 1, 0, "wd_switch");
        cyc(0, 4'b0011, 4'b0010, 1, 4'b0001, 2'd0, 1, 0, "nonowner_done");
        cyc(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "wd_release");

        // long hold: forced release only when the counter is built
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "hold0");
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "hold1");
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "hold2");
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "hold3");
`ifdef RR_ARB_TIMEOUT_EN
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0000, 2'd2, 0, 1, "to_release");
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "to_regrant");
`else
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "hold4");
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "hold5");
`endif
        cyc(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1, 0, "hold_more");

        // reset mid-grant clears outputs and pointer
        cyc(1, 4'b0100, 4'b0000, 1, 4'b0000, 2'd0, 0, 0, "rst_mid");
        cyc(0, 4'b1111, 4'b0000, 1, 4'b0001, 2'd0, 1, 0, "post_rst_gnt");

        tests++;
        assert (sb.size() == 0) else begin
            fails++; $error("FAIL sb_drain left %0d exp 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Four-requester round-robin arbiter with grant hold, sharing one common resource (bus, functional unit or memory port) between requesters without livelock. A requester that is granted keeps the resource until it signals completion or withdraws its request. Priority then rotates to the requester after the one just served. The block sits between the requesting units and the shared resource's select/enable inputs, and replaces per-cycle priority rotation with transaction-level fairness.

## Interface
- N_REQ, 4, number of requesters; power of two, ≥2
- TIMEOUT, 16, maximum cycles a grant is held before forced release (used only with the timeout feature)
- CLK  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  request lines, level-sensitive, held until served
- done  in  N_REQ  completion pulse; only `done[owner]` is honoured
- en  in  1  arbitration enable; gates new grants only
- gnt  out  N_REQ  registered one-hot grant, or all zero
- owner  out  $clog2(N_REQ)  index of current or last grantee
- busy  out  1  high while any grant is active
- timeout_err  out  1  one-cycle pulse on forced release

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: one grant held.
- Round-robin pointer `ptr` (log2 N_REQ bits):
  - Search starts at `ptr` and proceeds upward, wrapping modulo N_REQ.
  - The first set `req` bit wins.
- IDLE → BUSY: when `en` and `|req`. The winner is registered into `gnt` and `owner`; `busy`=1.
- BUSY, release condition: `done[owner] | ~req[owner]`. Withdrawal counts as release.
- On release:
  - `ptr` ← `owner+1`, wrapping from N_REQ-1 to 0.
  - If `en` and some other `req` is pending (the releasing requester excluded this cycle), go directly to the new winner, searched from the updated pointer. Back-to-back, no dead cycle; stay in BUSY.
  - Otherwise go to IDLE: `gnt`=0, `busy`=0.
- While BUSY, `en` low does not revoke the grant. `en` only blocks new grants.
- `done` bits of non-owners are ignored.
- `req` changes of non-owners during BUSY are ignored until release.
- `owner` retains its last value in IDLE.

## Timing
- Reset values: `gnt`=0, `owner`=0, `busy`=0, `timeout_err`=0, `ptr`=0, state IDLE.
- Grant latency: req sampled at edge t (state IDLE, `en`=1) → `gnt` visible after edge t, i.e. in cycle t+1.
- Release latency: `done[owner]` high in cycle t → `gnt` changes in cycle t+1, to the next winner or to 0.
- Minimum grant length is 1 cycle. `done` in the first granted cycle is legal.
- `rst` asserted mid-grant: all outputs and `ptr` clear at that edge. Reset has priority over all events.
- Reset value of `ptr` is 0, so requester 0 has first priority after reset.

## Configuration
- Macro `RR_ARB_TIMEOUT_EN`:
  - Defined: a hold counter clears on every new grant and increments each BUSY cycle. When the counter reaches TIMEOUT-1 without release, the block forces a release at the next edge:
    - `ptr` advances past the owner.
    - `timeout_err` pulses high for one cycle, coincident with the first cycle after release.
    - Re-arbitration proceeds as for a normal release.
  - Not defined: no counter is built; `timeout_err` is tied to 0.

## Structure
- Shared package `rr_arb_pkg`:
  - `N_REQ_DEF` constant
  - `arb_state_e` enum {IDLE, BUSY}
  - `REQ_IDX_W` constant
- Sub-module `rr_pick`: combinational. Takes the request vector, start pointer and exclude mask; outputs a one-hot winner, its index and a valid flag. It is instantiated once.
- All state (FSM, `ptr`, `gnt`, `owner`, timeout counter) lives in one `always_ff` block in `rr_bus_arbiter`.

## Test plan
- Reset: hold `rst` 2 cycles with `req`=1111 → `gnt`=0000, `busy`=0, `owner`=0. First grant after deassert is 0001.
- Full load: `req`=1111 constant, `done[owner]` pulsed 1 cycle after each grant → `gnt` sequence 0001, 0010, 0100, 1000, 0001, with no idle cycle between grants.
- Back-to-back with skip: `req`=1010 and owner 1; `done[1]` at cycle t → `gnt`=1000 at t+1, then `ptr`=0 after `done[3]`.
- Enable gating:
  - `en`=0, `req`=0100 → `gnt` stays 0000.
  - `en` rises at t → `gnt`=0100 at t+1.
  - `en` dropped while granted → grant held until `done[2]`.
- Withdrawal: owner 2 drops `req[2]` without `done`, while `req`=0001 pending → `gnt`=0001 next cycle.
- Timeout (`RR_ARB_TIMEOUT_EN`, TIMEOUT=4): `req`=0100 held, no `done` → `gnt`=0100 for 4 cycles, then `gnt`=0000 with `timeout_err`=1 for one cycle. Reset mid-hold clears everything.
